// File: rtl/easy_axi_wr_slv_pkg.sv
// ----------------------------------------------------------------------------
// easy_axi_wr_slv_pkg
// Shared constants for the AXI4 write-side responder: side-band field widths,
// burst type and response encodings, and a helper that recognises the legal
// WRAP burst lengths.
// ----------------------------------------------------------------------------
package easy_axi_wr_slv_pkg;

   // Fixed AXI4 field widths
   localparam int AXI_LEN_W    = 8;
   localparam int AXI_SIZE_W   = 3;
   localparam int AXI_BURST_W  = 2;
   localparam int AXI_RESP_W   = 2;
   localparam int AXI_LOCK_W   = 1;
   localparam int AXI_CACHE_W  = 4;
   localparam int AXI_PROT_W   = 3;
   localparam int AXI_QOS_W    = 4;
   localparam int AXI_REGION_W = 4;

   // Burst type encodings
   localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'd0;
   localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'd1;
   localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'd2;
   localparam logic [AXI_BURST_W-1:0] BURST_RSVD  = 2'd3;

   // Write response encodings
   localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'd0;
   localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'd2;

   // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/easy_axi_burst_addr.sv
// ----------------------------------------------------------------------------
// easy_axi_burst_addr
// Combinational next-beat address for an AXI4 burst.
//   addr      in   ADDR_W  address of the current beat
//   len       in   8       beats-1 of the burst
//   size      in   3       log2 bytes per beat
//   burst     in   2       FIXED / INCR / WRAP (reserved treated as FIXED)
//   next_addr out  ADDR_W  address of the following beat
// Arithmetic is modulo 2**ADDR_W; no overflow is reported.
// ----------------------------------------------------------------------------
module easy_axi_burst_addr
   import easy_axi_wr_slv_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic [AXI_LEN_W-1:0]   len,
   input  logic [AXI_SIZE_W-1:0]  size,
   input  logic [AXI_BURST_W-1:0] burst,
   output logic [ADDR_W-1:0]      next_addr
);

   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] wrap_mask;

   assign incr = ADDR_W'(1) << size;
   // The wrap window is (len+1) beats wide and aligned to its own size, so
   // window-1 is a mask selecting the offset within the window.
   assign wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);

   always_comb begin
      // NOTE: default assignment first so every path drives next_addr and no latch is inferred.
      next_addr = addr;
      case (burst)
         BURST_INCR: next_addr = addr + incr;
         BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
         default:    next_addr = addr;
      endcase
   end

endmodule

// File: rtl/easy_axi_wr_slv.sv
// ----------------------------------------------------------------------------
// easy_axi_wr_slv
// AXI4 write-side responder. Accepts one AW/W burst at a time, turns every
// accepted good beat into a registered one-cycle local write strobe, and
// returns a single B response per burst.
//   clk, rst              clock, asynchronous active-high reset
//   s_axi_aw*             write address channel (lock/cache/prot/qos/region ignored)
//   s_axi_w*              write data channel
//   s_axi_b*              write response channel (bid = captured awid)
//   wr_en                 one-cycle strobe per written beat
//   wr_addr               byte offset from SLV_BASE_ADDR
//   wr_data, wr_strb      registered copy of the beat's wdata / wstrb
// Errors (bad start address, size, burst type, WRAP shape, wlast placement,
// INCR running past the decoded span) turn the response into SLVERR. The
// burst always drains len+1 beats regardless.
// ----------------------------------------------------------------------------
module easy_axi_wr_slv
   import easy_axi_wr_slv_pkg::*;
#(
   parameter int                        AXI_ID_WIDTH   = 1,
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] SLV_BASE_ADDR  = 32'h4000_0000,
   parameter int                        SLV_ADDR_SPAN  = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [AXI_LEN_W-1:0]          s_axi_awlen,
   input  logic [AXI_SIZE_W-1:0]         s_axi_awsize,
   input  logic [AXI_BURST_W-1:0]        s_axi_awburst,
   input  logic [AXI_LOCK_W-1:0]         s_axi_awlock,
   input  logic [AXI_CACHE_W-1:0]        s_axi_awcache,
   input  logic [AXI_PROT_W-1:0]         s_axi_awprot,
   input  logic [AXI_QOS_W-1:0]          s_axi_awqos,
   input  logic [AXI_REGION_W-1:0]       s_axi_awregion,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                          s_axi_wlast,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
   output logic [AXI_RESP_W-1:0]         s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   output logic                          wr_en,
   output logic [AXI_ADDR_WIDTH-1:0]     wr_addr,
   output logic [AXI_DATA_WIDTH-1:0]     wr_data,
   output logic [AXI_DATA_WIDTH/8-1:0]   wr_strb
);

   localparam int STRB_W   = AXI_DATA_WIDTH / 8;
   localparam int MAX_SIZE = $clog2(STRB_W);
   localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(SLV_ADDR_SPAN);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]                state;
   logic [AXI_ADDR_WIDTH-1:0] cur_addr;
   logic [AXI_ADDR_WIDTH-1:0] nxt_addr;
   logic [AXI_LEN_W-1:0]      len_q;
   logic [AXI_LEN_W-1:0]      beat_cnt;
   logic [AXI_SIZE_W-1:0]     size_q;
   logic [AXI_BURST_W-1:0]    burst_q;
   logic                      err_q;     // burst will answer SLVERR
   logic                      no_wr_q;   // burst is malformed: write nothing

   logic aw_hs, w_hs, b_hs;
   logic [AXI_ADDR_WIDTH-1:0] size_mask;
   logic start_in_span, size_bad, burst_bad, wrap_bad, aw_bad;
   logic beat_in_span, beat_last, beat_err, beat_wr;

   // Side-band AW fields carry no meaning for a plain memory target.
   logic unused_sideband;
   assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                              s_axi_awqos, s_axi_awregion};

   assign aw_hs = s_axi_awvalid & s_axi_awready;
   assign w_hs  = s_axi_wvalid  & s_axi_wready;
   assign b_hs  = s_axi_bvalid  & s_axi_bready;

   // Unsigned offset compare also rejects addresses below the base, since
   // those wrap around to very large offsets.
   assign start_in_span = (s_axi_awaddr - SLV_BASE_ADDR) < SPAN;
   assign size_mask     = (AXI_ADDR_WIDTH'(1) << s_axi_awsize) - AXI_ADDR_WIDTH'(1);
   assign size_bad      = s_axi_awsize > AXI_SIZE_W'(MAX_SIZE);
   assign burst_bad     = (s_axi_awburst == BURST_RSVD);
   assign wrap_bad      = (s_axi_awburst == BURST_WRAP) &&
                          (!wrap_len_ok(s_axi_awlen) || ((s_axi_awaddr & size_mask) != '0));
   assign aw_bad        = !start_in_span || size_bad || burst_bad || wrap_bad;

   // Per-beat checks: an INCR burst may walk off the end of the span.
   assign beat_in_span = (cur_addr - SLV_BASE_ADDR) < SPAN;
   assign beat_last    = (beat_cnt == len_q);
   assign beat_err     = (s_axi_wlast != beat_last) || !beat_in_span;
   assign beat_wr      = !no_wr_q && beat_in_span;

   easy_axi_burst_addr #(
      .ADDR_W (AXI_ADDR_WIDTH)
   ) u_burst_addr (
      .addr      (cur_addr),
      .len       (len_q),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (nxt_addr)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         s_axi_awready <= 1'b1;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         s_axi_bid     <= '0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         wr_strb       <= '0;
         cur_addr      <= '0;
         len_q         <= '0;
         beat_cnt      <= '0;
         size_q        <= '0;
         burst_q       <= BURST_FIXED;
         err_q         <= 1'b0;
         no_wr_q       <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (aw_hs) begin
                  s_axi_bid     <= s_axi_awid;
                  cur_addr      <= s_axi_awaddr;
                  len_q         <= s_axi_awlen;
                  size_q        <= s_axi_awsize;
                  burst_q       <= s_axi_awburst;
                  beat_cnt      <= '0;
                  err_q         <= aw_bad;
                  no_wr_q       <= aw_bad;
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b1;
                  state         <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_hs) begin
                  if (beat_wr) begin
                     wr_en   <= 1'b1;
                     wr_addr <= cur_addr - SLV_BASE_ADDR;
                     wr_data <= s_axi_wdata;
                     wr_strb <= s_axi_wstrb;
                  end
                  cur_addr <= nxt_addr;
                  beat_cnt <= beat_cnt + 8'd1;
                  err_q    <= err_q | beat_err;
                  // Burst length comes from awlen, not wlast, so a
                  // misplaced wlast cannot shorten or stretch the burst.
                  if (beat_last) begin
                     s_axi_wready <= 1'b0;
                     s_axi_bvalid <= 1'b1;
                     s_axi_bresp  <= (err_q | beat_err) ? RESP_SLVERR : RESP_OKAY;
                     state        <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (b_hs) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               state         <= ST_IDLE;
               s_axi_awready <= 1'b1;
               s_axi_wready  <= 1'b0;
               s_axi_bvalid  <= 1'b0;
            end
         endcase
      end
   end

endmodule
